// File: rtl/hs_txn_profiler.sv
// Per-transaction timing profiler for an ap_ctrl_hs handshake; a record appears on m_* one cycle after its done.
// Backpressure: m_ready stalls the output FIFO; records arriving while it is full are dropped and counted.

// Generic FWFT FIFO: push when wr_vld && wr_rdy; full FIFO still accepts a push if it pops in the same cycle.
module hs_txn_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         ap_clk,
  input  logic         ap_rst_n,
  input  logic         wr_vld,
  output logic         wr_rdy,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         full, do_wr, do_rd;

  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_vld = (wr_ptr != rd_ptr);
  assign wr_rdy = !full || rd_rdy;
  assign do_wr  = wr_vld && wr_rdy;
  assign do_rd  = rd_vld && rd_rdy;
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr[AW-1:0]] <= wr_dat;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

module hs_txn_profiler #(
  parameter int TS_W       = 16,
  parameter int INFL_DEPTH = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            ap_clk,
  input  logic            ap_rst_n,
  input  logic            ap_start,
  input  logic            ap_ready,
  input  logic            ap_done,
  input  logic            ap_continue,
  input  logic            finish,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [TS_W-1:0] m_start_ts,
  output logic [TS_W-1:0] m_latency,
  output logic [TS_W-1:0] m_interval,
  output logic [TS_W-1:0] m_stall,
  output logic [15:0]     drop_cnt,
  output logic            err_infl_ovf,
  output logic            err_done_unf,
  output logic            idle
);
  typedef struct packed {
    logic [TS_W-1:0] start_ts;
    logic [TS_W-1:0] interval;
    logic [TS_W-1:0] stall;
  } ent_t;

  typedef struct packed {
    logic [TS_W-1:0] start_ts;
    logic [TS_W-1:0] latency;
    logic [TS_W-1:0] interval;
    logic [TS_W-1:0] stall;
  } rec_t;

  typedef enum logic {S_IDLE, S_WAIT_RDY} state_t;

  state_t          state_q, state_d;
  logic [TS_W-1:0] ts, pend_ts, last_start_ts, acc_start;
  logic            first_acc, pend_ld, accept, done_ev, bypass;
  ent_t            acc_ent, head_ent, src_ent;
  rec_t            rec_dat, out_rec;
  logic            infl_wr_vld, infl_wr_rdy, infl_rd_vld;
  logic            rec_vld, out_wr_rdy;

  // acc_start is the timestamp of the first ap_start cycle, valid whenever accept is high
  always_comb begin
    state_d   = state_q;
    pend_ld   = 1'b0;
    accept    = 1'b0;
    acc_start = pend_ts;
    case (state_q)
      S_IDLE: begin
        if (ap_start && !finish) begin
          pend_ld   = 1'b1;
          acc_start = ts;
          if (ap_ready) accept = 1'b1;
          else          state_d = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (ap_ready) begin
          accept  = 1'b1;
          state_d = S_IDLE;
        end else if (!ap_start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign acc_ent.start_ts = acc_start;
  assign acc_ent.stall    = ts - acc_start;
  assign acc_ent.interval = first_acc ? '0 : (acc_start - last_start_ts);

  assign done_ev     = ap_done && ap_continue;
  assign bypass      = accept && done_ev && !infl_rd_vld;
  assign infl_wr_vld = accept && !bypass;

  hs_txn_fifo #(.W($bits(ent_t)), .DEPTH(INFL_DEPTH)) u_infl (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .wr_vld   (infl_wr_vld),
    .wr_rdy   (infl_wr_rdy),
    .wr_dat   (acc_ent),
    .rd_vld   (infl_rd_vld),
    .rd_rdy   (done_ev),
    .rd_dat   (head_ent)
  );

  // An empty queue with a same-cycle accept completes straight from the accepting entry
  assign rec_vld          = done_ev && (infl_rd_vld || accept);
  assign src_ent          = infl_rd_vld ? head_ent : acc_ent;
  assign rec_dat.start_ts = src_ent.start_ts;
  assign rec_dat.latency  = ts - src_ent.start_ts;
  assign rec_dat.interval = src_ent.interval;
  assign rec_dat.stall    = src_ent.stall;

  hs_txn_fifo #(.W($bits(rec_t)), .DEPTH(FIFO_DEPTH)) u_out (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .wr_vld   (rec_vld),
    .wr_rdy   (out_wr_rdy),
    .wr_dat   (rec_dat),
    .rd_vld   (m_valid),
    .rd_rdy   (m_ready),
    .rd_dat   (out_rec)
  );

  assign m_start_ts = out_rec.start_ts;
  assign m_latency  = out_rec.latency;
  assign m_interval = out_rec.interval;
  assign m_stall    = out_rec.stall;
  assign idle       = (state_q == S_IDLE) && !infl_rd_vld && !m_valid;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q       <= S_IDLE;
      ts            <= '0;
      pend_ts       <= '0;
      last_start_ts <= '0;
      first_acc     <= 1'b1;
      drop_cnt      <= '0;
      err_infl_ovf  <= 1'b0;
      err_done_unf  <= 1'b0;
    end else begin
      state_q <= state_d;
      ts      <= ts + TS_W'(1);
      if (pend_ld) pend_ts <= ts;
      // interval reference advances on every acceptance, even one lost to overflow
      if (accept) begin
        last_start_ts <= acc_start;
        first_acc     <= 1'b0;
      end
      if (infl_wr_vld && !infl_wr_rdy)         err_infl_ovf <= 1'b1;
      if (done_ev && !infl_rd_vld && !accept)  err_done_unf <= 1'b1;
      if (rec_vld && !out_wr_rdy && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_hs_txn_profiler.sv
// Bench for hs_txn_profiler: directed scenarios with fixed expectations plus randomized traffic
// compared each cycle against a queue-based transaction model.
module tb_hs_txn_profiler;
  localparam int TS_W = 8;
  localparam int INFL = 4;
  localparam int FD   = 4;
  localparam int M    = 255;

  logic            ap_clk, ap_rst_n;
  logic            ap_start, ap_ready, ap_done, ap_continue, finish;
  logic            m_valid, m_ready;
  logic [TS_W-1:0] m_start_ts, m_latency, m_interval, m_stall;
  logic [15:0]     drop_cnt;
  logic            err_infl_ovf, err_done_unf, idle;

  int checks = 0;
  int errors = 0;

  hs_txn_profiler #(.TS_W(TS_W), .INFL_DEPTH(INFL), .FIFO_DEPTH(FD)) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .ap_start     (ap_start),
    .ap_ready     (ap_ready),
    .ap_done      (ap_done),
    .ap_continue  (ap_continue),
    .finish       (finish),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_start_ts   (m_start_ts),
    .m_latency    (m_latency),
    .m_interval   (m_interval),
    .m_stall      (m_stall),
    .drop_cnt     (drop_cnt),
    .err_infl_ovf (err_infl_ovf),
    .err_done_unf (err_done_unf),
    .idle         (idle)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Transaction-level reference: cycle count, pending start, in-flight list, expected output queue
  typedef struct {
    int start;
    int latency;
    int interval;
    int stall;
  } mrec_t;

  mrec_t mq[$];
  mrec_t mi[$];
  int    mts, mpend_ts, mlast, mdrop;
  bit    mpending, mfirst, movf, munf;

  always @(posedge ap_clk or negedge ap_rst_n) begin : model
    bit    acc, have;
    mrec_t e, r;
    int    t;
    if (!ap_rst_n) begin
      mq.delete();
      mi.delete();
      mts = 0; mpend_ts = 0; mlast = 0; mdrop = 0;
      mpending = 0; mfirst = 1; movf = 0; munf = 0;
    end else begin
      t = mts & M;
      acc = 0;
      have = 0;
      if (!mpending) begin
        if (ap_start && !finish) begin
          mpend_ts = t;
          if (ap_ready) acc = 1;
          else mpending = 1;
        end
      end else if (ap_ready) begin
        acc = 1;
        mpending = 0;
      end else if (!ap_start) begin
        mpending = 0;
      end
      e.start = mpend_ts; e.latency = 0; e.stall = 0; e.interval = 0;
      if (acc) begin
        e.stall    = (t - mpend_ts) & M;
        e.interval = mfirst ? 0 : ((mpend_ts - mlast) & M);
        mlast  = mpend_ts;
        mfirst = 0;
      end
      if (mq.size() > 0 && m_ready) mq.delete(0);
      r = e;
      if (ap_done && ap_continue) begin
        if (mi.size() > 0) begin
          r = mi[0];
          mi.delete(0);
          have = 1;
        end else if (acc) begin
          acc  = 0;
          have = 1;
        end else begin
          munf = 1;
        end
        if (have) begin
          r.latency = (t - r.start) & M;
          if (mq.size() < FD) mq.push_back(r);
          else if (mdrop < 65535) mdrop++;
        end
      end
      if (acc) begin
        if (mi.size() < INFL) mi.push_back(e);
        else movf = 1;
      end
      mts++;
    end
  end

  function automatic int cur_ts();
    return mts & M;
  endfunction

  task automatic clear_inputs();
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 1; finish = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    ap_rst_n = 0;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1;
  endtask

  task automatic wait_ts(input int t);
    for (int i = 0; i < 600; i++) begin
      if (cur_ts() == t) return;
      @(negedge ap_clk);
    end
    checks++; errors++;
    $display("FAIL wait_ts: ts never reached %0d", t);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({m_valid, idle, err_infl_ovf, err_done_unf} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0100", {m_valid, idle, err_infl_ovf, err_done_unf});
    end
    checks++;
    if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
    checks++;
    if ({m_start_ts, m_latency, m_interval, m_stall} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {m_start_ts, m_latency, m_interval, m_stall});
    end
  endtask

  task automatic test_single();
    do_reset();
    m_ready = 1;
    wait_ts(5);
    ap_start = 1; ap_ready = 1;
    @(negedge ap_clk);
    ap_start = 0; ap_ready = 0;
    wait_ts(12);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL single_early: m_valid got %b expected 0", m_valid); end
    ap_done = 1;
    @(negedge ap_clk);
    ap_done = 0;
    checks++;
    if (m_valid !== 1'b1 || {m_start_ts, m_latency, m_interval, m_stall} !== 32'h05070000) begin
      errors++;
      $display("FAIL single_rec: got v=%b %h expected v=1 05070000", m_valid, {m_start_ts, m_latency, m_interval, m_stall});
    end
    @(negedge ap_clk);
    checks++;
    if (idle !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got idle=%b v=%b expected idle=1 v=0", idle, m_valid);
    end
  endtask

  task automatic test_pipelined();
    do_reset();
    m_ready = 0;
    wait_ts(10);
    ap_start = 1; ap_ready = 1;
    repeat (2) @(negedge ap_clk);
    ap_start = 0; ap_ready = 0;
    wait_ts(20);
    ap_done = 1;
    repeat (2) @(negedge ap_clk);
    ap_done = 0;
    checks++;
    if (m_valid !== 1'b1 || {m_start_ts, m_latency, m_interval, m_stall} !== 32'h0a0a0000) begin
      errors++;
      $display("FAIL pipe_rec0: got v=%b %h expected v=1 0a0a0000", m_valid, {m_start_ts, m_latency, m_interval, m_stall});
    end
    m_ready = 1;
    @(negedge ap_clk);
    checks++;
    if (m_valid !== 1'b1 || {m_start_ts, m_latency, m_interval, m_stall} !== 32'h0b0a0100) begin
      errors++;
      $display("FAIL pipe_rec1: got v=%b %h expected v=1 0b0a0100", m_valid, {m_start_ts, m_latency, m_interval, m_stall});
    end
    @(negedge ap_clk);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL pipe_drained: m_valid got %b expected 0", m_valid); end
    wait_ts(30);
    ap_start = 1; ap_ready = 1;
    repeat (INFL) @(negedge ap_clk);
    checks++;
    if (err_infl_ovf !== 1'b0) begin errors++; $display("FAIL pipe_ovf_early: got %b expected 0", err_infl_ovf); end
    @(negedge ap_clk);
    ap_start = 0; ap_ready = 0;
    checks++;
    if (err_infl_ovf !== 1'b1) begin errors++; $display("FAIL pipe_ovf: got %b expected 1", err_infl_ovf); end
  endtask

  task automatic test_stall();
    do_reset();
    m_ready = 1;
    wait_ts(10);
    ap_start = 1;
    wait_ts(12);
    checks++;
    if (idle !== 1'b0) begin errors++; $display("FAIL stall_pending_idle: got %b expected 0", idle); end
    wait_ts(13);
    ap_ready = 1;
    @(negedge ap_clk);
    ap_start = 0; ap_ready = 0;
    wait_ts(15);
    ap_done = 1;
    @(negedge ap_clk);
    ap_done = 0;
    checks++;
    if (m_valid !== 1'b1 || {m_start_ts, m_latency, m_interval, m_stall} !== 32'h0a050003) begin
      errors++;
      $display("FAIL stall_rec: got v=%b %h expected v=1 0a050003", m_valid, {m_start_ts, m_latency, m_interval, m_stall});
    end
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] exp;
    do_reset();
    m_ready = 0;
    wait_ts(10);
    ap_start = 1; ap_ready = 1; ap_done = 1;
    repeat (6) @(negedge ap_clk);
    clear_inputs();
    checks++;
    if (drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_drop: got %0d expected 2", drop_cnt); end
    m_ready = 1;
    for (int k = 0; k < FD; k++) begin
      exp = {8'(10 + k), 8'd0, 8'((k == 0) ? 0 : 1), 8'd0};
      checks++;
      if (m_valid !== 1'b1 || {m_start_ts, m_latency, m_interval, m_stall} !== exp) begin
        errors++;
        $display("FAIL ovf_drain%0d: got v=%b %h expected v=1 %h", k, m_valid, {m_start_ts, m_latency, m_interval, m_stall}, exp);
      end
      @(negedge ap_clk);
    end
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: m_valid got %b expected 0", m_valid); end
  endtask

  task automatic test_wrap_zero();
    do_reset();
    m_ready = 1;
    wait_ts(250);
    ap_start = 1; ap_ready = 1;
    @(negedge ap_clk);
    ap_start = 0; ap_ready = 0;
    wait_ts(4);
    ap_done = 1;
    @(negedge ap_clk);
    ap_done = 0;
    checks++;
    if (m_valid !== 1'b1 || {m_start_ts, m_latency, m_interval, m_stall} !== 32'hfa0a0000) begin
      errors++;
      $display("FAIL wrap_rec: got v=%b %h expected v=1 fa0a0000", m_valid, {m_start_ts, m_latency, m_interval, m_stall});
    end
    wait_ts(20);
    ap_start = 1; ap_ready = 1; ap_done = 1;
    @(negedge ap_clk);
    clear_inputs();
    checks++;
    if (m_valid !== 1'b1 || {m_start_ts, m_latency, m_interval, m_stall} !== 32'h14001a00) begin
      errors++;
      $display("FAIL zero_lat_rec: got v=%b %h expected v=1 14001a00", m_valid, {m_start_ts, m_latency, m_interval, m_stall});
    end
  endtask

  task automatic test_finish();
    do_reset();
    m_ready = 1;
    wait_ts(5);
    ap_start = 1; ap_ready = 1;
    @(negedge ap_clk);
    finish = 1;
    @(negedge ap_clk);
    ap_start = 0; ap_ready = 0; ap_done = 1;
    @(negedge ap_clk);
    ap_done = 0;
    checks++;
    if (m_valid !== 1'b1 || m_start_ts !== 8'd5 || m_latency !== 8'd2) begin
      errors++;
      $display("FAIL finish_rec: got v=%b start=%0d lat=%0d expected v=1 start=5 lat=2", m_valid, m_start_ts, m_latency);
    end
    @(negedge ap_clk);
    checks++;
    if (m_valid !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL finish_blocked: got v=%b idle=%b expected v=0 idle=1", m_valid, idle);
    end
    finish = 0;
  endtask

  task automatic test_reset_midop();
    do_reset();
    m_ready = 0;
    wait_ts(5);
    ap_start = 1; ap_ready = 1; ap_done = 1;
    repeat (2) @(negedge ap_clk);
    clear_inputs();
    wait_ts(8);
    ap_start = 1; ap_ready = 1;
    repeat (3) @(negedge ap_clk);
    clear_inputs();
    checks++;
    if (m_valid !== 1'b1 || idle !== 1'b0) begin
      errors++;
      $display("FAIL midop_busy: got v=%b idle=%b expected v=1 idle=0", m_valid, idle);
    end
    #2 ap_rst_n = 0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || idle !== 1'b1 || drop_cnt !== 16'd0 || m_start_ts !== 8'd0) begin
      errors++;
      $display("FAIL midop_reset: got v=%b idle=%b drop=%0d start=%0d expected v=0 idle=1 drop=0 start=0",
               m_valid, idle, drop_cnt, m_start_ts);
    end
    @(negedge ap_clk);
    ap_rst_n = 1;
    checks++;
    if (err_done_unf !== 1'b0) begin errors++; $display("FAIL unf_early: got %b expected 0", err_done_unf); end
    ap_done = 1;
    @(negedge ap_clk);
    ap_done = 0;
    checks++;
    if (err_done_unf !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL unf: got err=%b v=%b expected err=1 v=0", err_done_unf, m_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      checks++;
      if (m_valid !== (mq.size() > 0)) begin
        errors++;
        $display("FAIL rnd_valid @%0d: got %b expected %b", i, m_valid, mq.size() > 0);
      end
      if (mq.size() > 0) begin
        exp = {8'(mq[0].start), 8'(mq[0].latency), 8'(mq[0].interval), 8'(mq[0].stall)};
        checks++;
        if ({m_start_ts, m_latency, m_interval, m_stall} !== exp) begin
          errors++;
          $display("FAIL rnd_rec @%0d: got %h expected %h", i, {m_start_ts, m_latency, m_interval, m_stall}, exp);
        end
      end
      checks++;
      if ({drop_cnt, err_infl_ovf, err_done_unf} !== {16'(mdrop), movf, munf}) begin
        errors++;
        $display("FAIL rnd_status @%0d: got drop=%0d ovf=%b unf=%b expected drop=%0d ovf=%b unf=%b",
                 i, drop_cnt, err_infl_ovf, err_done_unf, mdrop, movf, munf);
      end
      checks++;
      if (idle !== (!mpending && mi.size() == 0 && mq.size() == 0)) begin
        errors++;
        $display("FAIL rnd_idle @%0d: got %b", i, idle);
      end
      ap_start    = ($urandom_range(99) < 50);
      ap_ready    = ($urandom_range(99) < 45);
      ap_done     = ($urandom_range(99) < 35);
      ap_continue = ($urandom_range(99) < 80);
      finish      = ($urandom_range(99) < 5);
      m_ready     = ($urandom_range(99) < 55);
      @(negedge ap_clk);
    end
    clear_inputs();
  endtask

  initial begin
    ap_rst_n = 0;
    m_ready  = 0;
    clear_inputs();
    test_reset();
    test_single();
    test_pipelined();
    test_stall();
    test_fifo_overflow();
    test_wrap_zero();
    test_finish();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hs_txn_profiler.md
# hs_txn_profiler

Cycle-accurate profiler for one HLS block-level `ap_ctrl_hs` handshake (`ap_start`/`ap_ready`/`ap_done`/`ap_continue`).

- Sits beside a profiled instance such as the `fixed_to_float_top` converter or its sub-calls, and taps the same four signals the co-simulation status monitor samples.
- Emits one timing record per completed transaction into an output FIFO, drained by the CSV/status dump path.
- Replaces per-module CSV sampling with synthesizable, in-order, per-transaction records: start time, latency, start-to-start interval, input stall.

## Interface
- `TS_W`, 16: timestamp and record field width; all differences are modulo 2^TS_W.
- `INFL_DEPTH`, 4: maximum in-flight (accepted, not yet done) transactions; power of two.
- `FIFO_DEPTH`, 8: output record FIFO depth; power of two.

- `ap_clk` in 1: sole clock.
- `ap_rst_n` in 1: reset, asynchronous assert, active-low.
- `ap_start` in 1: tapped start of the profiled block.
- `ap_ready` in 1: tapped ready.
- `ap_done` in 1: tapped done.
- `ap_continue` in 1: tapped continue; tie to 1 when the block has none.
- `finish` in 1: end of run; blocks new acceptances.
- `m_valid` out 1: record available.
- `m_ready` in 1: consumer takes record.
- `m_start_ts` out TS_W: timestamp of first `ap_start` cycle.
- `m_latency` out TS_W: done cycle minus start_ts.
- `m_interval` out TS_W: start_ts minus previous start_ts; 0 for first transaction after reset.
- `m_stall` out TS_W: accept cycle minus start_ts.
- `drop_cnt` out 16: records lost to full FIFO; saturates at 0xFFFF.
- `err_infl_ovf` out 1: sticky; acceptance while in-flight queue full.
- `err_done_unf` out 1: sticky; done with nothing in flight.
- `idle` out 1: in-flight queue empty, FIFO empty, no pending start.

## Operation

**Timestamp**
- Free-running `ts` counter, 0 in the first cycle after reset release, +1 per cycle, wraps.

**Start tracking** (FSM with states IDLE and WAIT_RDY)
- IDLE, `ap_start`=1, `finish`=0: latch `pend_ts = ts`.
  - If `ap_ready`=1 in the same cycle: accept immediately, stay IDLE.
  - Otherwise go to WAIT_RDY.
- WAIT_RDY, `ap_ready`=1: accept, return to IDLE.
- WAIT_RDY, `ap_start` drops without ready: return to IDLE with no record (protocol violation, ignored).

**Accept**
- Push {`pend_ts`, stall = `ts − pend_ts`} into the in-flight queue.
- Update `last_start_ts`.
- Interval = `pend_ts − last_start_ts`, forced to 0 if this is the first acceptance since reset.
- Interval is stored alongside the queue entry.

**Completion** (`ap_done && ap_continue`)
- Pop the oldest in-flight entry.
- Form the record with latency = `ts − entry.start_ts`.
- Push the record to the output FIFO.

**Simultaneous accept and done with the queue empty**
- Bypass: the record uses the accepting entry directly.
- A latency-0 block (start, ready and done all in one cycle) yields latency 0, stall 0.

**Simultaneous accept and done with the queue non-empty**
- Pop and push happen in the same cycle.
- Occupancy is unchanged, and this is legal even when the queue is full.

**Error cases**
- Acceptance with the queue full and no simultaneous pop: entry discarded, `err_infl_ovf` set.
- Done with the queue empty and no bypass: ignored, `err_done_unf` set.
- FIFO full at record push: record discarded, `drop_cnt`++.
  - If `m_ready` pops in the same cycle, the push succeeds.

**`finish`**
- Gates new starts only.
- In-flight transactions still complete and emit records.

## Timing
- Reset values:
  - `ts`, all queue and FIFO pointers, `drop_cnt`, sticky errors: 0.
  - `m_valid`: 0; all `m_*` data: 0.
  - `idle`: 1.
  - FSM: IDLE.
  - First-acceptance flag set.
- Record for a completion at cycle T: `m_valid`=1 at T+1.
- Output FIFO is first-word-fall-through. Records leave in completion order.
- A record transfers on `m_valid && m_ready`, one record per cycle sustained.
- `m_*` data holds while `m_valid && !m_ready`.
- Reset assertion mid-operation clears all state immediately. Queued records are lost, with no partial outputs.

## Test plan
1. **Single transaction.** `ap_start`+`ap_ready` at ts 5, `ap_done` at ts 12, `m_ready`=1 → one record {start 5, latency 7, interval 0, stall 0}, `m_valid` at ts 13, `idle`=1 at ts 14.
2. **Pipelined.** Accepts at ts 10 and 11, dones at ts 20 and 21 → records {10,10,0,0} then {11,10,1,0}. With INFL_DEPTH=2, a third accept at 12 without a pop sets `err_infl_ovf`.
3. **Stall.** `ap_start` high from ts 10, `ap_ready` at ts 13, done at ts 15 → {start 10, latency 5, stall 3}.
4. **FIFO overflow.** FIFO_DEPTH=4, `m_ready`=0, 6 completions → exactly 4 records buffered, `drop_cnt`=2. Raising `m_ready` drains them in order.
5. **Wrap and zero latency.** TS_W=8, start+ready at ts 250, done at ts 4 after wrap → latency 10. A separate start+ready+done in one cycle → latency 0, stall 0.
6. **Reset and protocol errors.** Async `ap_rst_n` low with 3 in flight and 2 records queued → `m_valid`=0, `idle`=1, counters 0 within the same cycle. After release, `ap_done` with nothing in flight → `err_done_unf`=1 and no record.
